// File: rtl/seq_tx_1001_if.sv
// Handshake and serial-line bundle for the 1001-sync frame transmitter.
interface seq_tx_1001_if #(
  parameter int PAYLOAD_W = 8
);
  logic [PAYLOAD_W-1:0] data_in;
  logic                 load;
  logic                 ready;
  logic                 data_out;
  logic                 busy;
  logic                 done;
  logic [7:0]           frame_cnt;

  modport master (
    output data_in, load,
    input  ready, data_out, busy, done, frame_cnt
  );

  modport slave (
    input  data_in, load,
    output ready, data_out, busy, done, frame_cnt
  );
endinterface

// File: rtl/seq_tx_1001.sv
// Serial frame transmitter: sync 1001, PAYLOAD_W bits MSB first, GAP zeros,
// with a one-word holding register so frames can run back to back.
module seq_tx_1001 #(
  parameter int PAYLOAD_W = 8,
  parameter int GAP       = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  seq_tx_1001_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_e;

  localparam logic [4:0] LAST_BIT = 5'(PAYLOAD_W - 1);
  localparam logic [4:0] LAST_GAP = 5'(GAP - 1);

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [4:0]           bit_q, bit_d;
  logic [4:0]           gap_q, gap_d;
  logic [PAYLOAD_W-1:0] sh_q, sh_d;
  logic [PAYLOAD_W-1:0] hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic                 line_q, line_d;
  logic                 done_q, done_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 accept;

  function automatic logic sync_bit(input logic [1:0] i);
    return (i == 2'd0) || (i == 2'd3);
  endfunction

  // Registers hold the bit currently on the line; next-state logic picks the
  // following bit so data_out stays a pure flop output.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    sh_d       = sh_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    line_d     = 1'b0;
    accept     = bus.load && !hold_vld_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SYNC;
          idx_d   = 2'd0;
          sh_d    = bus.data_in;
          line_d  = 1'b1;
        end
      end
      S_SYNC: begin
        if (accept) begin
          hold_d     = bus.data_in;
          hold_vld_d = 1'b1;
        end
        if (idx_q == 2'd3) begin
          state_d = S_DATA;
          bit_d   = 5'd0;
          line_d  = sh_q[PAYLOAD_W-1];
          sh_d    = sh_q << 1;
        end else begin
          idx_d  = idx_q + 2'd1;
          line_d = sync_bit(idx_q + 2'd1);
        end
      end
      S_DATA: begin
        if (accept) begin
          hold_d     = bus.data_in;
          hold_vld_d = 1'b1;
        end
        if (bit_q == LAST_BIT) begin
          state_d = S_GAP;
          gap_d   = 5'd0;
        end else begin
          bit_d  = bit_q + 5'd1;
          line_d = sh_q[PAYLOAD_W-1];
          sh_d   = sh_q << 1;
        end
      end
      S_GAP: begin
        if (gap_q == LAST_GAP) begin
          // Held word wins; with an empty hold a load this edge bypasses it.
          if (hold_vld_q) begin
            state_d    = S_SYNC;
            idx_d      = 2'd0;
            sh_d       = hold_q;
            hold_vld_d = 1'b0;
            line_d     = 1'b1;
          end else if (accept) begin
            state_d = S_SYNC;
            idx_d   = 2'd0;
            sh_d    = bus.data_in;
            line_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (accept) begin
            hold_d     = bus.data_in;
            hold_vld_d = 1'b1;
          end
          gap_d = gap_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_GAP) && (gap_d == LAST_GAP);
    cnt_d  = cnt_q + {7'd0, done_d};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      bit_q      <= 5'd0;
      gap_q      <= 5'd0;
      sh_q       <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      line_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bit_q      <= bit_d;
      gap_q      <= gap_d;
      sh_q       <= sh_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      line_q     <= line_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.ready     = !hold_vld_q;
  assign bus.data_out  = line_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.frame_cnt = cnt_q;

endmodule

// File: tb/tb_seq_tx_1001.sv
// Bench for seq_tx_1001: vector table, directed corner sequences and random
// traffic checked against a bit-queue frame model.
module tb_seq_tx_1001;
  localparam int PW = 8;
  localparam int GP = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_tx_1001_if #(.PAYLOAD_W(PW)) tif ();
  seq_tx_1001_if #(.PAYLOAD_W(1))  tif1 ();

  seq_tx_1001 #(.PAYLOAD_W(PW), .GAP(GP)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (tif.slave)
  );

  seq_tx_1001 #(.PAYLOAD_W(1), .GAP(1)) dut1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (tif1.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: queue of line bits still to be shown; front = bit on the line now.
  bit         mq[$];
  bit         mh_v;
  logic [7:0] mh_w;
  logic [7:0] mcnt;

  typedef struct {
    logic       ld;
    logic [7:0] d;
    logic       out;
    logic       busy;
    logic       done;
    logic       rdy;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] w);
    mq.push_back(1'b1); mq.push_back(1'b0); mq.push_back(1'b0); mq.push_back(1'b1);
    for (int i = PW - 1; i >= 0; i--) mq.push_back(w[i]);
    for (int i = 0; i < GP; i++) mq.push_back(1'b0);
  endtask

  task automatic model_reset();
    mq.delete();
    mh_v = 1'b0;
    mh_w = 8'h00;
    mcnt = 8'h00;
  endtask

  task automatic model_step(input logic ld, input logic [7:0] d);
    bit acc;
    acc = ld && !mh_v;
    if (mq.size() > 0) begin
      void'(mq.pop_front());
      if (mq.size() == 0) begin
        if (mh_v) begin
          push_frame(mh_w);
          mh_v = 1'b0;
        end else if (acc) begin
          push_frame(d);
        end
      end else if (acc) begin
        mh_v = 1'b1;
        mh_w = d;
      end
    end else if (acc) begin
      push_frame(d);
    end
    if (mq.size() == 1) mcnt = mcnt + 8'd1;
  endtask

  task automatic check_model();
    chk("line", {31'd0, tif.data_out}, {31'd0, (mq.size() > 0) ? mq[0] : 1'b0});
    chk("busy", {31'd0, tif.busy}, {31'd0, mq.size() > 0});
    chk("done", {31'd0, tif.done}, {31'd0, mq.size() == 1});
    chk("ready", {31'd0, tif.ready}, {31'd0, !mh_v});
    chk("frame_cnt", {24'd0, tif.frame_cnt}, {24'd0, mcnt});
  endtask

  task automatic cyc(input logic ld, input logic [7:0] d);
    tif.load    = ld;
    tif.data_in = d;
    @(posedge clk);
    model_step(ld, d);
    #1;
    check_model();
  endtask

  task automatic drain();
    for (int k = 0; k < 80 && tif.busy; k++) cyc(1'b0, 8'h00);
    chk("drain_idle", {31'd0, tif.busy}, 32'd0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_line", {31'd0, tif.data_out}, 32'd0);
    chk("rst_busy", {31'd0, tif.busy}, 32'd0);
    chk("rst_done", {31'd0, tif.done}, 32'd0);
    chk("rst_cnt", {24'd0, tif.frame_cnt}, 32'd0);
    chk("rst_ready", {31'd0, tif.ready}, 32'd1);
    #2 rst_n = 1'b1;
  endtask

  task automatic cyc1(input logic ld, input logic b);
    tif1.load       = ld;
    tif1.data_in[0] = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [13:0] pat;
    logic [5:0]  pat1;
    logic [7:0]  cnt0;
    int          n;
    int          seen;

    rst_n = 1'b0;
    tif.load = 1'b0;  tif.data_in = '0;
    tif1.load = 1'b0; tif1.data_in = '0;
    model_reset();

    #3;
    chk("rst0_line", {31'd0, tif.data_out}, 32'd0);
    chk("rst0_busy", {31'd0, tif.busy}, 32'd0);
    chk("rst0_done", {31'd0, tif.done}, 32'd0);
    chk("rst0_cnt", {24'd0, tif.frame_cnt}, 32'd0);
    chk("rst0_ready", {31'd0, tif.ready}, 32'd1);
    #9 rst_n = 1'b1;

    // Single A5 frame, load on the first edge after reset release.
    pat = 14'b1001_10100101_00;
    for (int i = 0; i < 15; i++) begin
      tbl[i].ld   = (i == 0);
      tbl[i].d    = (i == 0) ? 8'hA5 : 8'h00;
      tbl[i].out  = (i < 14) ? pat[13 - i] : 1'b0;
      tbl[i].busy = (i < 14);
      tbl[i].done = (i == 13);
      tbl[i].rdy  = 1'b1;
    end
    for (int i = 0; i < 15; i++) begin
      tif.load    = tbl[i].ld;
      tif.data_in = tbl[i].d;
      @(posedge clk);
      model_step(tbl[i].ld, tbl[i].d);
      #1;
      chk($sformatf("tbl%0d_line", i), {31'd0, tif.data_out}, {31'd0, tbl[i].out});
      chk($sformatf("tbl%0d_busy", i), {31'd0, tif.busy}, {31'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_done", i), {31'd0, tif.done}, {31'd0, tbl[i].done});
      chk($sformatf("tbl%0d_ready", i), {31'd0, tif.ready}, {31'd0, tbl[i].rdy});
    end
    chk("tbl_cnt", {24'd0, tif.frame_cnt}, 32'd1);

    // Back-to-back FF then 00 queued during payload.
    cnt0 = tif.frame_cnt;
    n = 0;
    cyc(1'b1, 8'hFF); n += int'(tif.busy);
    for (int k = 0; k < 4; k++) begin cyc(1'b0, 8'h00); n += int'(tif.busy); end
    cyc(1'b1, 8'h00); n += int'(tif.busy);
    chk("b2b_ready", {31'd0, tif.ready}, 32'd0);
    for (int k = 0; k < 60; k++) begin
      cyc(1'b0, 8'h00);
      if (!tif.busy) break;
      n++;
    end
    chk("b2b_busy_run", n, 28);
    chk("b2b_cnt_delta", {24'd0, tif.frame_cnt - cnt0}, 32'd2);

    // Bypass on the last gap cycle.
    cyc(1'b1, 8'h5A);
    for (int k = 0; k < 30 && !tif.done; k++) cyc(1'b0, 8'h00);
    chk("byp_reach_done", {31'd0, tif.done}, 32'd1);
    cyc(1'b1, 8'h3C);
    chk("byp_line", {31'd0, tif.data_out}, 32'd1);
    chk("byp_busy", {31'd0, tif.busy}, 32'd1);
    chk("byp_ready", {31'd0, tif.ready}, 32'd1);
    drain();

    // Hold full: third word refused.
    cyc(1'b1, 8'h11);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h22);
    chk("hold_ready0", {31'd0, tif.ready}, 32'd0);
    cyc(1'b1, 8'h33);
    chk("hold_ready1", {31'd0, tif.ready}, 32'd0);
    drain();

    // Reset mid-payload of C3 with 77 held.
    cyc(1'b1, 8'hC3);
    cyc(1'b1, 8'h77);
    for (int k = 0; k < 6; k++) cyc(1'b0, 8'h00);
    do_reset();
    cyc(1'b1, 8'h5E);
    drain();

    // Random traffic.
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 3) == 0, 8'($urandom));
    drain();

    // Frame counter wrap.
    do_reset();
    seen = 0;
    for (int k = 0; k < 5000 && seen < 256; k++) begin
      cyc(1'b1, 8'($urandom));
      if (mq.size() == 1) seen++;
    end
    chk("wrap_seen", seen, 256);
    chk("wrap_cnt", {24'd0, tif.frame_cnt}, 32'd0);
    chk("wrap_done", {31'd0, tif.done}, 32'd1);
    drain();

    // PAYLOAD_W=1, GAP=1 instance: 6-cycle frames 1001,b,0.
    for (int f = 0; f < 2; f++) begin
      pat1 = {4'b1001, (f == 0), 1'b0};
      for (int i = 0; i < 7; i++) begin
        cyc1(i == 0, f == 0);
        chk($sformatf("p1f%0d_line%0d", f, i), {31'd0, tif1.data_out}, {31'd0, (i < 6) ? pat1[5 - i] : 1'b0});
        chk($sformatf("p1f%0d_done%0d", f, i), {31'd0, tif1.done}, {31'd0, i == 5});
        chk($sformatf("p1f%0d_busy%0d", f, i), {31'd0, tif1.busy}, {31'd0, i < 6});
      end
    end
    chk("p1_cnt", {24'd0, tif1.frame_cnt}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seq_tx_1001.md
SEQ_TX_1001 -- requirements
Module: seq_tx_1001

Interface
REQ-001 Parameter: PAYLOAD_W, default 8, payload bits per frame (legal range 1..16).
REQ-002 Parameter: GAP, default 2, idle-zero cycles after each payload (legal range 1..15).
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release is synchronous to clock.
REQ-005 data_in  input  PAYLOAD_W  payload word to transmit, MSB first.
REQ-006 load  input  1  request to transmit data_in; a transfer occurs when load and ready are both high at a rising edge.
REQ-007 ready  output  1  block can accept a word this cycle.
REQ-008 data_out  output  1  registered serial line; low when idle.
REQ-009 busy  output  1  high while a frame (sync, payload or gap) is on the line.
REQ-010 done  output  1  one-cycle pulse on the final gap cycle of each frame.
REQ-011 frame_cnt  output  8  count of completed frames, wraps 255 -> 0.

Function
REQ-012 Frame format SHALL be: sync 1,0,0,1 (4 cycles), then PAYLOAD_W data bits MSB first, then GAP cycles of 0; total 4+PAYLOAD_W+GAP cycles.
REQ-013 FSM SHALL have states IDLE, SYNC, DATA, GAP; one line bit per cycle in every non-IDLE state.
REQ-014 IDLE: data_out=0, busy=0; on accepted load -> SYNC, data_in captured into shift register.
REQ-015 The first sync bit (1) SHALL appear on data_out in the cycle immediately after the accepting edge (latency 1 cycle).
REQ-016 SYNC: 2-bit index steps 0..3 emitting 1,0,0,1; after index 3 -> DATA.
REQ-017 DATA: shift register shifts left one bit per cycle, data_out = current MSB; after PAYLOAD_W bits -> GAP.
REQ-018 GAP: data_out=0 for exactly GAP cycles; done=1 and frame_cnt increments on the last GAP cycle.
REQ-019 A single-entry holding register SHALL buffer one word; ready = !hold_valid.
REQ-020 Accepted load while busy SHALL write the holding register and set hold_valid.
REQ-021 At end of GAP: if hold_valid -> SYNC with held word, hold_valid cleared (no IDLE cycle between frames); else if load is high that edge -> SYNC with data_in (bypass); else -> IDLE.
REQ-022 Accepted load in IDLE SHALL bypass the holding register; hold_valid stays 0.
REQ-023 data_in SHALL be sampled only at the accepting edge; later changes do not affect a queued or active frame.
REQ-024 No line pattern 1,0,0,1 beyond the sync field is guaranteed absent; payload is transmitted unmodified.
REQ-025 busy SHALL be high in SYNC, DATA and GAP, low only in IDLE.

Reset
REQ-026 On reset low: state=IDLE, data_out=0, busy=0, done=0, frame_cnt=0, hold_valid=0, shift register and indices cleared.
REQ-027 Reset asserted mid-frame SHALL abort the frame and discard any held word; no done pulse, frame_cnt not incremented.
REQ-028 ready SHALL be 1 during and immediately after reset.
REQ-029 load asserted in the first edge after reset release SHALL be accepted normally.

Verification
REQ-030 Single frame, defaults: load=1 with data_in=8'hA5 one cycle -> data_out over 14 cycles = 1001 10100101 00, done on cycle 14, frame_cnt=1, then IDLE with data_out=0.
REQ-031 Back-to-back: load 8'hFF, then load 8'h00 during payload -> ready drops after second accept, second sync begins the cycle after first frame's last gap bit; 28 contiguous busy cycles; frame_cnt=2.
REQ-032 Bypass at end of gap: hold empty, load 8'h3C asserted on last GAP cycle -> next frame starts with no idle cycle, hold_valid stays 0.
REQ-033 Hold full: third load while hold_valid=1 -> ready=0, word not accepted, not transmitted; line output unchanged.
REQ-034 Reset mid-payload (after bit 3 of 8'hC3) -> data_out=0 immediately, busy=0, frame_cnt=0, held word lost; next load transmits full fresh frame.
REQ-035 Wrap and parameters: 256 frames -> frame_cnt returns to 0 with done still pulsing; PAYLOAD_W=1, GAP=1 -> frames of 6 cycles, data_out 1001,b,0.
